// File: rtl/hazard_pkg.sv
// Shared types and encodings for the ID-stage hazard scoreboard.
// Scoreboard entries carry a fixed-width rd field; narrower register files zero-extend into it.
package hazard_pkg;

  localparam int REG_AW_MAX = 8;
  localparam int FWD_RF     = 0;
  localparam int BR_FREEZE  = 0;
  localparam int BR_PNT     = 1;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  load;
  } sb_entry_t;

  function automatic int FWD_STAGE(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the ID stage and the hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_AW     = 5,
  parameter int PIPE_DEPTH = 3
);
  localparam int SEL_W = $clog2(PIPE_DEPTH + 1);

  logic              id_valid;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              use_rs1;
  logic              use_rs2;
  logic [REG_AW-1:0] rd;
  logic              wr_rd;
  logic              is_load;
  logic              is_branch;
  logic              branch_taken;
  logic              pc_load;
  logic              if_id_load;
  logic              bubble;
  logic              flush_if_id;
  logic [SEL_W-1:0]  fwd_a_sel;
  logic [SEL_W-1:0]  fwd_b_sel;
  logic              stall;

  modport master (
    output id_valid, rs1, rs2, use_rs1, use_rs2, rd, wr_rd, is_load, is_branch, branch_taken,
    input  pc_load, if_id_load, bubble, flush_if_id, fwd_a_sel, fwd_b_sel, stall
  );

  modport slave (
    input  id_valid, rs1, rs2, use_rs1, use_rs2, rd, wr_rd, is_load, is_branch, branch_taken,
    output pc_load, if_id_load, bubble, flush_if_id, fwd_a_sel, fwd_b_sel, stall
  );

endinterface

// File: rtl/hazard_sb_shift.sv
// In-flight destination tracker: entry0 is EX, the highest index is the oldest stage.
module hazard_sb_shift
  import hazard_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  sb_entry_t                  i_entry0,
  output sb_entry_t [PIPE_DEPTH-1:0] o_entries
);

  sb_entry_t [PIPE_DEPTH-1:0] r_entries;

  // Shift one stage toward the oldest entry every cycle; the oldest drops off.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_entries <= '0;
    end else begin
      r_entries[0] <= i_entry0;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        r_entries[k] <= r_entries[k-1];
      end
    end
  end

  assign o_entries = r_entries;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: stall/bubble control, operand forwarding selects and
// branch freeze/flush, all decided combinationally from the scoreboard and the ID inputs.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int FWD_EN     = 1,
  parameter int LOAD_LAT   = 1,
  parameter int RF_BYPASS  = 1,
  parameter int BR_MODE    = 0,
  parameter int BR_PENALTY = 2
) (
  input logic                i_clock,
  input logic                i_reset_n,
  hazard_scoreboard_if.slave bus
);

  localparam int SEL_W        = $clog2(PIPE_DEPTH + 1);
  localparam int BC_W         = $clog2(BR_PENALTY + 1);
  localparam int PAD_W        = REG_AW_MAX - REG_AW;
  localparam bit FREEZE_ON_BR = (BR_MODE != BR_PNT);

  sb_entry_t [PIPE_DEPTH-1:0] w_entries;
  sb_entry_t                  w_entry0;
  logic [REG_AW_MAX-1:0]      w_rs1;
  logic [REG_AW_MAX-1:0]      w_rs2;
  logic [REG_AW_MAX-1:0]      w_rd;
  logic [PIPE_DEPTH-1:0]      w_m1;
  logic [PIPE_DEPTH-1:0]      w_m2;
  logic [PIPE_DEPTH-1:0]      w_ld_young;
  logic [SEL_W-1:0]           w_sel_a;
  logic [SEL_W-1:0]           w_sel_b;
  logic [BC_W-1:0]            r_bcnt;
  logic                       w_freeze;
  logic                       w_hazard;
  logic                       w_fwd_ok;
  logic                       w_issue;
  logic                       w_pc_load;
  logic                       w_if_id_load;
  logic                       w_bubble;
  logic                       w_flush;
  logic                       w_stall;

  assign w_rs1    = {{PAD_W{1'b0}}, bus.rs1};
  assign w_rs2    = {{PAD_W{1'b0}}, bus.rs2};
  assign w_rd     = {{PAD_W{1'b0}}, bus.rd};
  assign w_freeze = (r_bcnt != '0);

  hazard_sb_shift #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_sb (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_entry0  (w_entry0),
    .o_entries (w_entries)
  );

  // Per-entry source matches; with RF_BYPASS the oldest stage has already reached the register file.
  always_comb begin
    w_m1       = '0;
    w_m2       = '0;
    w_ld_young = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (RF_BYPASS != 0 && k == PIPE_DEPTH - 1) begin
        w_m1[k] = 1'b0;
        w_m2[k] = 1'b0;
      end else begin
        w_m1[k] = bus.use_rs1 && w_entries[k].valid && (w_entries[k].rd == w_rs1) && (bus.rs1 != '0);
        w_m2[k] = bus.use_rs2 && w_entries[k].valid && (w_entries[k].rd == w_rs2) && (bus.rs2 != '0);
      end
      w_ld_young[k] = w_entries[k].load && (k < LOAD_LAT);
    end
  end

  // Without forwarding any pending producer blocks; with it only a load that is still too young.
  always_comb begin
    if (FWD_EN == 0) begin
      w_hazard = bus.id_valid && (|(w_m1 | w_m2));
    end else begin
      w_hazard = bus.id_valid && (|((w_m1 | w_m2) & w_ld_young));
    end
  end

  // Youngest producer wins: scan from oldest to youngest so the last hit sticks.
  always_comb begin
    w_sel_a = SEL_W'(FWD_RF);
    w_sel_b = SEL_W'(FWD_RF);
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      if (w_m1[k]) begin
        w_sel_a = SEL_W'(FWD_STAGE(k));
      end else begin
        w_sel_a = w_sel_a;
      end
      if (w_m2[k]) begin
        w_sel_b = SEL_W'(FWD_STAGE(k));
      end else begin
        w_sel_b = w_sel_b;
      end
    end
  end

  // Priority: reset, redirect flush, branch freeze, data hazard, normal issue.
  always_comb begin
    w_pc_load    = 1'b1;
    w_if_id_load = 1'b1;
    w_bubble     = 1'b0;
    w_flush      = 1'b0;
    w_stall      = 1'b0;
    w_issue      = 1'b0;
    if (!i_reset_n) begin
      w_issue = 1'b0;
    end else if (bus.branch_taken) begin
      w_bubble = 1'b1;
      w_flush  = 1'b1;
    end else if (w_freeze || w_hazard) begin
      w_pc_load    = 1'b0;
      w_if_id_load = 1'b0;
      w_bubble     = 1'b1;
      w_stall      = 1'b1;
    end else begin
      w_issue = bus.id_valid;
    end
  end

  assign w_fwd_ok        = i_reset_n && (FWD_EN != 0) && !w_freeze && !w_hazard;
  assign bus.pc_load     = w_pc_load;
  assign bus.if_id_load  = w_if_id_load;
  assign bus.bubble      = w_bubble;
  assign bus.flush_if_id = w_flush;
  assign bus.stall       = w_stall;
  assign bus.fwd_a_sel   = w_fwd_ok ? w_sel_a : SEL_W'(FWD_RF);
  assign bus.fwd_b_sel   = w_fwd_ok ? w_sel_b : SEL_W'(FWD_RF);

  // New EX entry: the issuing instruction's destination, or a bubble.
  always_comb begin
    w_entry0       = '0;
    w_entry0.valid = w_issue && bus.wr_rd && (bus.rd != '0);
    w_entry0.rd    = w_issue ? w_rd : '0;
    w_entry0.load  = w_issue && bus.is_load;
  end

  // Branch freeze countdown; a redirect cancels any remaining freeze.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bcnt <= '0;
    end else if (bus.branch_taken) begin
      r_bcnt <= '0;
    end else if (w_freeze) begin
      r_bcnt <= r_bcnt - BC_W'(1);
    end else if (FREEZE_ON_BR && w_issue && bus.is_branch) begin
      r_bcnt <= BC_W'(BR_PENALTY);
    end else begin
      r_bcnt <= r_bcnt;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three configurations (forwarding, no forwarding,
// predict-not-taken) share one stimulus stream and are checked against a behavioural model.
module tb_hazard_scoreboard;

  localparam int NCFG = 3;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       br;
    logic       bt;
  } stim_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  stim_t                 s;
  logic [NCFG-1:0][8:0]  obs;
  int                    n_cmp = 0;
  int                    n_bad = 0;

  bit m_v  [NCFG][3];
  int m_rd [NCFG][3];
  bit m_ld [NCFG][3];
  int m_bcnt [NCFG];

  always #5 clk = ~clk;

  // cfg0: forwarding + freeze, cfg1: no forwarding + freeze, cfg2: forwarding + predict-not-taken
  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    hazard_scoreboard_if #(.REG_AW(5), .PIPE_DEPTH(3)) bus ();
    hazard_scoreboard #(
      .REG_AW(5), .PIPE_DEPTH(3), .FWD_EN((g == 1) ? 0 : 1), .LOAD_LAT(1),
      .RF_BYPASS(1), .BR_MODE((g == 2) ? 1 : 0), .BR_PENALTY(2)
    ) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
    );
    assign bus.id_valid     = s.v;
    assign bus.rs1          = s.rs1;
    assign bus.use_rs1      = s.u1;
    assign bus.rs2          = s.rs2;
    assign bus.use_rs2      = s.u2;
    assign bus.rd           = s.rd;
    assign bus.wr_rd        = s.wr;
    assign bus.is_load      = s.ld;
    assign bus.is_branch    = s.br;
    assign bus.branch_taken = s.bt;
    assign obs[g] = {bus.pc_load, bus.if_id_load, bus.bubble, bus.flush_if_id,
                     bus.fwd_a_sel, bus.fwd_b_sel, bus.stall};
  end

  function automatic stim_t st(bit v, int r1, bit u1, int r2, bit u2, int rd, bit wr, bit ld, bit br, bit bt);
    stim_t t;
    t.v = v; t.rs1 = 5'(r1); t.u1 = u1; t.rs2 = 5'(r2); t.u2 = u2;
    t.rd = 5'(rd); t.wr = wr; t.ld = ld; t.br = br; t.bt = bt;
    return t;
  endfunction

  function automatic bit cfg_fwd(int c); return c != 1; endfunction
  function automatic bit cfg_pnt(int c); return c == 2; endfunction

  // A producer is visible to a read while it is in EX or MEM; WB is already in the register file.
  function automatic bit m_hit(int c, int k, int r, bit u);
    return u && r != 0 && k < 2 && m_v[c][k] && m_rd[c][k] == r;
  endfunction

  function automatic int m_sel(int c, int r, bit u);
    for (int k = 0; k < 3; k++) if (m_hit(c, k, r, u)) return k + 1;
    return 0;
  endfunction

  function automatic bit m_hazard(int c);
    bit h = 1'b0;
    if (!s.v) return 1'b0;
    for (int k = 0; k < 3; k++)
      if (m_hit(c, k, s.rs1, s.u1) || m_hit(c, k, s.rs2, s.u2))
        if (!cfg_fwd(c) || (m_ld[c][k] && k < 1)) h = 1'b1;
    return h;
  endfunction

  function automatic logic [8:0] model_out(int c);
    bit blocked;
    int sa;
    int sb;
    blocked = (m_bcnt[c] > 0) || m_hazard(c);
    sa = (cfg_fwd(c) && !blocked) ? m_sel(c, s.rs1, s.u1) : 0;
    sb = (cfg_fwd(c) && !blocked) ? m_sel(c, s.rs2, s.u2) : 0;
    if (s.bt) return {4'b1111, 2'(sa), 2'(sb), 1'b0};
    if (blocked) return {4'b0010, 2'(sa), 2'(sb), 1'b1};
    return {4'b1100, 2'(sa), 2'(sb), 1'b0};
  endfunction

  task automatic model_step(int c);
    bit issue;
    issue = s.v && !s.bt && m_bcnt[c] == 0 && !m_hazard(c);
    for (int k = 2; k > 0; k--) begin
      m_v[c][k] = m_v[c][k-1]; m_rd[c][k] = m_rd[c][k-1]; m_ld[c][k] = m_ld[c][k-1];
    end
    m_v[c][0]  = issue && s.wr && s.rd != 5'd0;
    m_rd[c][0] = int'(s.rd);
    m_ld[c][0] = issue && s.ld;
    if (s.bt) m_bcnt[c] = 0;
    else if (m_bcnt[c] > 0) m_bcnt[c] = m_bcnt[c] - 1;
    else if (!cfg_pnt(c) && issue && s.br) m_bcnt[c] = 2;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCFG; c++) begin
      m_bcnt[c] = 0;
      for (int k = 0; k < 3; k++) begin m_v[c][k] = 1'b0; m_rd[c][k] = 0; m_ld[c][k] = 1'b0; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) for (int c = 0; c < NCFG; c++) model_step(c);
    #1;
  endtask

  task automatic flush_pipe();
    s = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    s = st(1, 5, 1, 5, 1, 5, 1, 1, 1, 0);
    #1;
    for (int c = 0; c < NCFG; c++) begin
      n_cmp++;
      if (obs[c] !== 9'b1100_0000_0) begin
        n_bad++; $display("FAIL reset cfg%0d: got %b want %b", c, obs[c], 9'b1100_0000_0);
      end
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    stim_t seq[5];
    flush_pipe();
    seq[0] = st(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    for (int i = 1; i < 5; i++) seq[i] = st(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      s = seq[i]; #1;
      for (int c = 0; c < NCFG; c++) begin
        n_cmp++;
        if (obs[c] !== model_out(c)) begin
          n_bad++; $display("FAIL load_use[%0d] cfg%0d: got %b want %b", i, c, obs[c], model_out(c));
        end
      end
      if (i == 1) begin
        n_cmp++;
        if (obs[0] !== 9'b0010_0000_1) begin n_bad++; $display("FAIL load_use_stall: got %b want %b", obs[0], 9'b0010_0000_1); end
      end
      if (i == 2) begin
        n_cmp += 2;
        if (obs[0] !== 9'b1100_1010_0) begin n_bad++; $display("FAIL load_use_fwd: got %b want %b", obs[0], 9'b1100_1010_0); end
        if (obs[1] !== 9'b0010_0000_1) begin n_bad++; $display("FAIL nofwd_stall2: got %b want %b", obs[1], 9'b0010_0000_1); end
      end
      if (i == 3) begin
        n_cmp++;
        if (obs[1] !== 9'b1100_0000_0) begin n_bad++; $display("FAIL nofwd_release: got %b want %b", obs[1], 9'b1100_0000_0); end
      end
      tick();
    end
  endtask

  task automatic test_forward_chain();
    stim_t seq[4];
    flush_pipe();
    seq[0] = st(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    seq[1] = st(1, 0, 0, 7, 1, 8, 1, 0, 0, 0);
    seq[2] = st(1, 0, 0, 7, 1, 9, 1, 0, 0, 0);
    seq[3] = st(1, 0, 0, 7, 1, 9, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      s = seq[i]; #1;
      for (int c = 0; c < NCFG; c++) begin
        n_cmp++;
        if (obs[c] !== model_out(c)) begin
          n_bad++; $display("FAIL fwd_chain[%0d] cfg%0d: got %b want %b", i, c, obs[c], model_out(c));
        end
      end
      if (i == 1 || i == 2) begin
        n_cmp += 2;
        if (obs[0] !== {4'b1100, 2'd0, 2'(i), 1'b0}) begin n_bad++; $display("FAIL fwd_b_sel[%0d]: got %b want %b", i, obs[0], {4'b1100, 2'd0, 2'(i), 1'b0}); end
        if (obs[1] !== 9'b0010_0000_1) begin n_bad++; $display("FAIL nofwd_chain_stall[%0d]: got %b want %b", i, obs[1], 9'b0010_0000_1); end
      end
      if (i == 3) begin
        n_cmp++;
        if (obs[1] !== 9'b1100_0000_0) begin n_bad++; $display("FAIL nofwd_chain_release: got %b want %b", obs[1], 9'b1100_0000_0); end
      end
      tick();
    end
  endtask

  task automatic test_youngest_wins();
    stim_t seq[5];
    flush_pipe();
    seq[0] = st(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    seq[1] = st(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    seq[2] = st(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    seq[3] = st(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    seq[4] = st(1, 3, 1, 3, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      s = seq[i]; #1;
      for (int c = 0; c < NCFG; c++) begin
        n_cmp++;
        if (obs[c] !== model_out(c)) begin
          n_bad++; $display("FAIL youngest[%0d] cfg%0d: got %b want %b", i, c, obs[c], model_out(c));
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (obs[0] !== 9'b1100_0100_0) begin n_bad++; $display("FAIL youngest_sel: got %b want %b", obs[0], 9'b1100_0100_0); end
      end
      if (i == 3) begin
        n_cmp++;
        if (obs[2] !== 9'b1100_0000_0) begin n_bad++; $display("FAIL x0_read: got %b want %b", obs[2], 9'b1100_0000_0); end
      end
      tick();
    end
  endtask

  task automatic test_branch_freeze();
    stim_t seq[8];
    flush_pipe();
    seq[0] = st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i < 8; i++) seq[i] = st(1, 2, 1, 0, 0, 4, 1, 0, 0, 0);
    seq[4] = seq[0];
    seq[6] = st(1, 2, 1, 0, 0, 4, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      s = seq[i]; #1;
      for (int c = 0; c < NCFG; c++) begin
        n_cmp++;
        if (obs[c] !== model_out(c)) begin
          n_bad++; $display("FAIL branch[%0d] cfg%0d: got %b want %b", i, c, obs[c], model_out(c));
        end
      end
      if (i == 1 || i == 2 || i == 5) begin
        n_cmp++;
        if (obs[0] !== 9'b0010_0000_1) begin n_bad++; $display("FAIL freeze[%0d]: got %b want %b", i, obs[0], 9'b0010_0000_1); end
      end
      if (i == 1) begin
        n_cmp++;
        if (obs[2] !== 9'b1100_0000_0) begin n_bad++; $display("FAIL pnt_no_freeze: got %b want %b", obs[2], 9'b1100_0000_0); end
      end
      if (i == 3 || i == 7) begin
        n_cmp++;
        if (obs[0] !== 9'b1100_0000_0) begin n_bad++; $display("FAIL freeze_end[%0d]: got %b want %b", i, obs[0], 9'b1100_0000_0); end
      end
      if (i == 6) begin
        n_cmp++;
        if (obs[0] !== 9'b1111_0000_0) begin n_bad++; $display("FAIL flush_in_freeze: got %b want %b", obs[0], 9'b1111_0000_0); end
      end
      tick();
    end
  endtask

  task automatic test_pnt_flush();
    stim_t seq[3];
    flush_pipe();
    seq[0] = st(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
    seq[1] = st(1, 6, 1, 0, 0, 10, 1, 0, 0, 1);
    seq[2] = st(1, 10, 1, 6, 1, 11, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      s = seq[i]; #1;
      for (int c = 0; c < NCFG; c++) begin
        n_cmp++;
        if (obs[c] !== model_out(c)) begin
          n_bad++; $display("FAIL pnt_flush[%0d] cfg%0d: got %b want %b", i, c, obs[c], model_out(c));
        end
      end
      if (i == 1) begin
        n_cmp++;
        if ({obs[2][8:5], obs[2][0]} !== 5'b1111_0) begin n_bad++; $display("FAIL flush_beats_stall: got %b want %b", {obs[2][8:5], obs[2][0]}, 5'b1111_0); end
      end
      if (i == 2) begin
        n_cmp++;
        if (obs[2] !== 9'b1100_0010_0) begin n_bad++; $display("FAIL flushed_not_issued: got %b want %b", obs[2], 9'b1100_0010_0); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_freeze();
    flush_pipe();
    s = st(1, 0, 0, 0, 0, 5, 1, 1, 1, 0);
    tick();
    s = st(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    for (int c = 0; c < NCFG; c++) begin
      n_cmp++;
      if (obs[c] !== model_out(c)) begin
        n_bad++; $display("FAIL pre_reset cfg%0d: got %b want %b", c, obs[c], model_out(c));
      end
    end
    #1 rst_n = 1'b0; #1;
    model_reset();
    for (int c = 0; c < NCFG; c++) begin
      n_cmp++;
      if (obs[c] !== 9'b1100_0000_0) begin
        n_bad++; $display("FAIL async_reset cfg%0d: got %b want %b", c, obs[c], 9'b1100_0000_0);
      end
    end
    tick();
    rst_n = 1'b1; #1;
    n_cmp++;
    if (obs[0] !== 9'b1100_0000_0) begin n_bad++; $display("FAIL post_reset_read: got %b want %b", obs[0], 9'b1100_0000_0); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      s.v   = ($urandom_range(0, 9) < 8);
      s.rs1 = 5'($urandom_range(0, 3));
      s.u1  = 1'($urandom_range(0, 1));
      s.rs2 = 5'($urandom_range(0, 3));
      s.u2  = 1'($urandom_range(0, 1));
      s.rd  = 5'($urandom_range(0, 3));
      s.wr  = ($urandom_range(0, 3) != 0);
      s.ld  = ($urandom_range(0, 2) == 0);
      s.br  = ($urandom_range(0, 9) == 0);
      s.bt  = ($urandom_range(0, 14) == 0);
      #1;
      for (int c = 0; c < NCFG; c++) begin
        n_cmp++;
        if (obs[c] !== model_out(c)) begin
          n_bad++; $display("FAIL random[%0d] cfg%0d: got %b want %b", i, c, obs[c], model_out(c));
        end
      end
      tick();
    end
  endtask

  initial begin
    s = '0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_load_use();
    test_forward_chain();
    test_youngest_wins();
    test_branch_freeze();
    test_pnt_flush();
    test_reset_mid_freeze();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the ID-stage hazard unit. It sits beside decode.
- Tracks in-flight destination registers in a PIPE_DEPTH-deep scoreboard shift register.
- Generates stall/bubble controls, per-operand forwarding selects, and branch freeze/flush controls.
- Supports configurable forwarding mode, load-use latency and branch policy.

Parameters:
REG_AW, 5, register address width (register 0 is hardwired zero)
PIPE_DEPTH, 3, stages after ID that can hold a pending write (entry0=EX, entry1=MEM, entry2=WB)
FWD_EN, 1, 1 = forward from scoreboard stages; 0 = stall until result written
LOAD_LAT, 1, number of youngest entries in which a load result is not yet forwardable (1..PIPE_DEPTH-1)
RF_BYPASS, 1, 1 = register file writes before it reads, so the oldest entry never causes a hazard
BR_MODE, 0, 0 = freeze fetch after a branch issues; 1 = predict-not-taken
BR_PENALTY, 2, freeze length in cycles for BR_MODE 0 (>=1)

Ports:
clock  in  1  pipeline clock
reset  in  1  asynchronous, active-low; clears scoreboard and branch counter
id_valid  in  1  ID holds a real instruction
rs1, rs2  in  REG_AW  source registers
use_rs1, use_rs2  in  1  operand actually read
rd  in  REG_AW  destination register
wr_rd  in  1  instruction writes rd
is_load  in  1  instruction is a load
is_branch  in  1  instruction is a branch/jump
branch_taken  in  1  EX resolved a redirect this cycle
pc_load  out  1  PC register enable
if_id_load  out  1  IF/ID register enable
bubble  out  1  zero the control fields entering ID/EX
flush_if_id  out  1  invalidate IF/ID contents
fwd_a_sel, fwd_b_sel  out  $clog2(PIPE_DEPTH+1)  0 = register file, k = scoreboard entry k-1
stall  out  1  data hazard or freeze active (performance counter tap)

Behaviour:
- Scoreboard entry fields: {valid, rd, load}. Every cycle all entries shift one place towards the oldest entry; the oldest entry is dropped.
- Entry0 load value:
  - issue accepted (id_valid, no stall, no flush): {wr_rd && rd!=0, rd, is_load};
  - otherwise: bubble {0,0,0}.
- Source match on entry k: use_rsX && entry_k.valid && entry_k.rd==rsX && rsX!=0.
- Excluded entry: if RF_BYPASS=1, the oldest entry never matches.
- Data hazard (id_valid required):
  - FWD_EN=0: any match.
  - FWD_EN=1: a match on entry k<LOAD_LAT with entry_k.load set.
- Forward select, FWD_EN=1, no hazard: fwd_X_sel = k+1 for the smallest matching k (youngest producer wins); 0 if no match.
- Forward select when FWD_EN=0 or stalled: fwd_X_sel = 0.
- Branch counter bcnt: width $clog2(BR_PENALTY+1), reset 0.
  - BR_MODE 0: an accepted issue with is_branch loads BR_PENALTY. While bcnt!=0 it decrements each cycle, and the freeze is active.
  - BR_MODE 1: bcnt is never loaded.
- Output priority (highest first):
  - reset: bcnt=0, entries invalid. Outputs pc_load=1, if_id_load=1, bubble=0, flush_if_id=0, sel=0, stall=0.
  - branch_taken: flush_if_id=1, bubble=1, pc_load=1, if_id_load=1, stall=0. bcnt cleared the same edge; the ID instruction is not issued.
  - freeze (bcnt!=0): pc_load=0, if_id_load=0, bubble=1, stall=1.
  - data hazard: pc_load=0, if_id_load=0, bubble=1, stall=1.
  - otherwise: pc_load=1, if_id_load=1, bubble=0, flush_if_id=0.
- Timing:
  - All outputs are combinational from registered state plus the current ID inputs; decision latency is 0 cycles.
  - State updates on rising clock.
  - Load-use with LOAD_LAT=1: exactly 1 stall cycle; generally LOAD_LAT-k cycles for a producer in entry k.
- Boundary cases:
  - id_valid=0: no hazard, no issue; entry0 gets a bubble.
  - rd=0 writes are never tracked.
  - rs1==rs2 hazard: single stall, both selects identical.
  - branch_taken during a data stall: the flush wins and the stall is dropped.
  - Reset asserted mid-freeze: the counter clears immediately (asynchronous).

Decomposition:
- Package hazard_pkg:
  - sb_entry_t struct {valid, rd, load};
  - forward-select encoding constants FWD_RF=0 and FWD_STAGE(k)=k+1;
  - BR_FREEZE=0 and BR_PNT=1.
- One sub-module, hazard_sb_shift: PIPE_DEPTH-entry shift register with async active-low clear. Its outputs are the entry vectors.
- Match, priority and counter logic live in the top module.

Test Plan:
- Load x5 in entry0, then ID add uses rs1=x5 (FWD_EN=1, LOAD_LAT=1) -> 1 cycle pc_load=0, bubble=1; next cycle fwd_a_sel=2.
- add x7 issued, next instruction reads rs2=x7, then another reads x7 -> fwd_b_sel=1, then 2, no stall. Same sequence with FWD_EN=0 -> stall 2 cycles (RF_BYPASS=1), then sel=0.
- Entries 0 and 1 both write x3 and ID reads x3 -> fwd_a_sel=1 (youngest wins). Same sequence with rs=x0 -> sel=0, no stall.
- BR_MODE 0, BR_PENALTY=2, branch issues -> pc_load=0, bubble=1 for exactly 2 cycles; branch_taken in cycle 2 -> flush_if_id=1, pc_load=1, bcnt=0.
- BR_MODE 1, branch_taken pulse while a load-use stall is pending -> flush_if_id=1, bubble=1, pc_load=1, stall=0; entry0 bubble.
- Reset low mid-freeze with a valid load in entry0 -> outputs immediately 1,1,0,0, sel 0; after release, a dependent read does not stall.
